// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection sequencer: A/B red-yellow-green lamps, all-red clearance
// between directions, demand-driven green on road A and a latched pedestrian walk phase.
// All phase timing runs off a tick produced by an internal prescaler.
module traffic_phase_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned T_GREEN  = 8,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 1,
  parameter int unsigned T_WALK   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_b,
  input  logic ped_req,
  output logic a_r,
  output logic a_y,
  output logic a_g,
  output logic b_r,
  output logic b_y,
  output logic b_g,
  output logic walk,
  output logic ped_pending
);

  localparam int unsigned MaxGy = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
  localparam int unsigned MaxAw = (T_ALLRED > T_WALK) ? T_ALLRED : T_WALK;
  localparam int unsigned MaxT  = (MaxGy > MaxAw) ? MaxGy : MaxAw;
  localparam int unsigned PhW   = $clog2(MaxT + 1);
  localparam int unsigned PreW  = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    StAGrn,
    StAYel,
    StRedAb,
    StBGrn,
    StBYel,
    StRedBa,
    StWalk
  } state_e;

  state_e           state_q, state_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic             ped_q, ped_d;
  logic             next_b_q, next_b_d;
  logic             tick;
  logic             moved;
  logic             enter_walk;

  assign tick = (pre_q == PreW'(TICK_DIV - 1));

  // Next-state decision; transitions only ever happen on a tick cycle.
  always_comb begin
    state_d  = state_q;
    next_b_d = next_b_q;
    if (tick) begin
      case (state_q)
        StAGrn: begin
          // Road A keeps green until its minimum has elapsed and someone is waiting.
          if ((phase_q >= PhW'(T_GREEN - 1)) && (sensor_b || ped_q)) state_d = StAYel;
        end
        StAYel: if (phase_q == PhW'(T_YELLOW - 1)) state_d = StRedAb;
        StRedAb: begin
          if (phase_q == PhW'(T_ALLRED - 1)) begin
            state_d  = ped_q ? StWalk : StBGrn;
            next_b_d = 1'b1;
          end
        end
        StBGrn: if (phase_q == PhW'(T_GREEN - 1)) state_d = StBYel;
        StBYel: if (phase_q == PhW'(T_YELLOW - 1)) state_d = StRedBa;
        StRedBa: begin
          if (phase_q == PhW'(T_ALLRED - 1)) begin
            state_d  = ped_q ? StWalk : StAGrn;
            next_b_d = 1'b0;
          end
        end
        StWalk: if (phase_q == PhW'(T_WALK - 1)) state_d = next_b_q ? StBGrn : StAGrn;
        default: state_d = StAGrn;
      endcase
    end
  end

  // Prescaler, saturating phase counter and pedestrian latch; timers restart on every move.
  always_comb begin
    moved      = (state_d != state_q);
    enter_walk = (state_d == StWalk) && (state_q != StWalk);
    pre_d      = tick ? '0 : pre_q + PreW'(1);
    phase_d    = phase_q;
    if (tick && (phase_q != '1)) phase_d = phase_q + PhW'(1);
    if (moved) begin
      pre_d   = '0;
      phase_d = '0;
    end
    // A request on the WALK entry cycle wins over the clear and books another walk.
    ped_d = ped_req | (ped_q & ~enter_walk);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StAGrn;
      pre_q    <= '0;
      phase_q  <= '0;
      ped_q    <= 1'b0;
      next_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      phase_q  <= phase_d;
      ped_q    <= ped_d;
      next_b_q <= next_b_d;
    end
  end

  // Moore lamp decode.
  always_comb begin
    a_r  = 1'b0;
    a_y  = 1'b0;
    a_g  = 1'b0;
    b_r  = 1'b0;
    b_y  = 1'b0;
    b_g  = 1'b0;
    walk = 1'b0;
    case (state_q)
      StAGrn: begin a_g = 1'b1; b_r = 1'b1; end
      StAYel: begin a_y = 1'b1; b_r = 1'b1; end
      StBGrn: begin a_r = 1'b1; b_g = 1'b1; end
      StBYel: begin a_r = 1'b1; b_y = 1'b1; end
      StWalk: begin a_r = 1'b1; b_r = 1'b1; walk = 1'b1; end
      default: begin a_r = 1'b1; b_r = 1'b1; end
    endcase
  end

  assign ped_pending = ped_q;

endmodule
